instr_fetch_unit: RTL and testbench

- IF stage of the RISC-V pipeline. Owns the PC, drives the instruction-memory port and reads its combinational output.
- Buffers fetched words in a small prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (taken branches) from downstream and flushes wrong-path words.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 74 +++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_INSTR_W = 32;
  localparam int PC_STEP     = 4;
  localparam int RESET_PC    = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy view of the prefetch queue, derived from its count.
  typedef enum logic [1:0] {
    FS_EMPTY   = 2'd0,
    FS_PARTIAL = 2'd1,
    FS_FULL    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer with push/pop/flush; flush wins over push and pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push into a full queue overwrites the slot being popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches one word per cycle into a prefetch queue,
// and flushes on redirect. Decode handshake: a word moves when if_valid && if_ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  i_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  fetch_state_t       state;
  logic               pop;
  logic               push;
  logic               unused_redirect_lsbs;

  always_comb begin
    state = FS_PARTIAL;
    if (count == '0)                 state = FS_EMPTY;
    else if (count == CNT_W'(DEPTH)) state = FS_FULL;
  end

  assign if_valid = (state != FS_EMPTY);
  assign pop      = if_valid & if_ready;
  assign push     = !redirect_valid & ((state != FS_FULL) | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (push)      pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= ADDR_W'(RESET_PC);
    else        pc_q <= pc_d;
  end

  assign i_mem_addr = pc_q;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop & !redirect_valid),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, i_mem_data}),
    .rdata_o (head),
    .count_o (count)
  );

  assign {if_pc, if_instr} = head;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 6;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] i_mem_addr;
  logic [IW-1:0] i_mem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mem_addr     (i_mem_addr),
    .i_mem_data     (i_mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  logic [IW-1:0] rom [16];
  assign i_mem_data = rom[i_mem_addr[5:2]];

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC as a number, the prefetch queue as a plain queue.
  logic [AW-1:0] m_pc;
  fetch_entry_t  m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = '0;
      m_q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (m_q.size() > 0) && if_ready;
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (redirect_valid) begin
        m_pc = redirect_pc & 6'h3C;
        m_q.delete();
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back('{pc: m_pc, instr: rom[m_pc >> 2]});
          m_pc = m_pc + 6'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("mem_addr", 32'(i_mem_addr), 32'(m_pc));
      check("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("if_pc", 32'(if_pc), 32'(m_q[0].pc));
        check("if_instr", if_instr, m_q[0].instr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Short reset pulse strictly between edges; checks the asynchronous clear.
  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_addr", 32'(i_mem_addr), 32'd0);
    check("async_rst_pc", 32'(if_pc), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] tgt;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    rom[0] = 32'h0000_0163;
    rom[1] = 32'h001F_8083;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    #2;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", 32'(if_pc), 32'd0);
    check("rst_addr", 32'(i_mem_addr), 32'd0);

    // Streaming from reset release.
    tick();
    rst_n = 1'b1;
    if_ready = 1'b1;
    chk_en = 1'b1;
    tick();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc", 32'(if_pc), 32'd0);
    check("first_instr", if_instr, 32'h0000_0163);
    tick();
    check("second_pc", 32'(if_pc), 32'd4);
    check("second_instr", if_instr, 32'h001F_8083);
    repeat (6) tick();

    // Fill the queue, reset while full, then hold backpressure.
    if_ready = 1'b0;
    repeat (3) tick();
    pulse_reset();
    tick();
    tick();
    check("bp_addr", 32'(i_mem_addr), 32'd8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_head_pc", 32'(if_pc), 32'd0);
      check("bp_hold_addr", 32'(i_mem_addr), 32'd8);
    end
    if_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("bp_drain_pc", 32'(if_pc), 32'(4 * k));
    end

    // Redirect with queue holding pc 8 and 12.
    if_ready = 1'b0;
    pulse_reset();
    tick();
    tick();
    if_ready = 1'b1;
    tick();
    tick();
    if_ready = 1'b0;
    check("rd_head_before", 32'(if_pc), 32'd8);
    redirect_valid = 1'b1;
    redirect_pc = 6'h2F;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(if_valid), 32'd0);
    check("rd_target_addr", 32'(i_mem_addr), 32'h2C);
    tick();
    check("rd_target_valid", 32'(if_valid), 32'd1);
    check("rd_target_pc", 32'(if_pc), 32'h2C);

    // Redirect coincident with a pop on a full queue.
    tick();
    tgt = AW'($urandom_range(0, 63));
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect_valid = 1'b0;
    check("rdpop_flush_valid", 32'(if_valid), 32'd0);
    tick();
    check("rdpop_target_pc", 32'(if_pc), 32'(tgt & 6'h3C));

    // PC wrap past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 6'd60;
    tick();
    redirect_valid = 1'b0;
    check("wrap_flush_valid", 32'(if_valid), 32'd0);
    tick();
    check("wrap_pc0", 32'(if_pc), 32'd60);
    tick();
    check("wrap_pc1", 32'(if_pc), 32'd0);
    tick();
    check("wrap_pc2", 32'(if_pc), 32'd4);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick();
      if_ready = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
